// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TDO serializer: default word width,
// length-field sizing helper and the serializer state encoding.
package jtag_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // Bits needed to hold a bit count from 0 up to and including width.
  function automatic int len_w(input int width);
    return $clog2(width + 1);
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/tdo_shift_reg.sv
// Loadable TDO shift register with a remaining-bit down-counter; all updates
// happen on the falling edge of TCK so TDO is stable at the next rising edge.
module tdo_shift_reg
  import jtag_pkg::*;
#(
  parameter int   WIDTH      = WIDTH_DEFAULT,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int  LEN_W      = len_w(WIDTH)
) (
  input  logic             clk_tck,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             advance,
  input  logic             load,
  input  logic [WIDTH-1:0] load_word,  // first bit already at the shift-out end
  input  logic [LEN_W-1:0] load_len,   // 1..WIDTH
  output logic             tdo,
  output logic             done,
  output logic             last
);

  logic [WIDTH-1:0] sh_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;
  logic             empty;

  assign empty = (cnt_q == '0);
  assign last  = (cnt_q == LEN_W'(1));

  // The active word is consumed from sh_q; a fresh word is consumed directly
  // from load_word so its first bit appears on the very edge it is pulled.
  always_comb begin
    src     = empty ? load_word : sh_q;
    out_bit = MSB_FIRST ? src[WIDTH-1] : src[0];
    shifted = MSB_FIRST ? (src << 1) : (src >> 1);
  end

  always_ff @(negedge clk_tck or negedge reset_n) begin
    if (!reset_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
      tdo   <= IDLE_LEVEL;
      done  <= 1'b0;
    end else if (clear) begin
      sh_q  <= '0;
      cnt_q <= '0;
      tdo   <= IDLE_LEVEL;
      done  <= 1'b0;
    end else if (!advance) begin
      done <= 1'b0;
      if (empty) tdo <= IDLE_LEVEL;
    end else if (!empty) begin
      tdo   <= out_bit;
      sh_q  <= shifted;
      cnt_q <= cnt_q - LEN_W'(1);
      done  <= last;
    end else if (load) begin
      tdo   <= out_bit;
      sh_q  <= shifted;
      cnt_q <= load_len - LEN_W'(1);
      done  <= (load_len == LEN_W'(1));
    end else begin
      tdo  <= IDLE_LEVEL;
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/jtag_tdo_serializer.sv
// TDO serializer: valid/ready load port, one-word holding buffer for gap-free
// streaming, per-word length, pause on shift_en low and abort.
module jtag_tdo_serializer
  import jtag_pkg::*;
#(
  parameter int   WIDTH      = WIDTH_DEFAULT,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0,
  localparam int  LEN_W      = len_w(WIDTH)
) (
  input  logic             clk_tck,
  input  logic             reset_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [LEN_W-1:0] load_len,
  input  logic             shift_en,
  input  logic             abort,
  output logic             tdo,
  output logic             busy,
  output logic             done,
  output state_t           state_dbg
);

  // Handshake: a word transfers on a falling edge where load_valid and
  // load_ready are both high; load_ready depends only on hold_full and abort.

  logic [WIDTH-1:0] hold_data_q;
  logic [LEN_W-1:0] hold_len_q;
  logic             hold_full_q;
  state_t           state_q;
  state_t           state_d;
  logic             take;
  logic             pull;
  logic             last_bit;
  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] aligned;

  // Zero or oversize lengths mean a full-width word.
  always_comb begin
    if (load_len == '0 || load_len > LEN_W'(WIDTH)) eff_len = LEN_W'(WIDTH);
    else                                            eff_len = load_len;
  end

  // MSB-first words are left-justified so bit [len-1] sits at the top.
  always_comb begin
    if (MSB_FIRST) aligned = hold_data_q << (LEN_W'(WIDTH) - hold_len_q);
    else           aligned = hold_data_q;
  end

  always_ff @(negedge clk_tck or negedge reset_n) begin
    if (!reset_n) begin
      hold_data_q <= '0;
      hold_len_q  <= '0;
      hold_full_q <= 1'b0;
    end else if (abort) begin
      hold_full_q <= 1'b0;
    end else if (take) begin
      hold_data_q <= load_data;
      hold_len_q  <= eff_len;
      hold_full_q <= 1'b1;
    end else if (pull) begin
      hold_full_q <= 1'b0;
    end
  end

  always_ff @(negedge clk_tck or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (pull && hold_len_q != LEN_W'(1)) state_d = ST_SHIFT;
        ST_SHIFT: if (shift_en && last_bit)            state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    load_ready = !hold_full_q && !abort;
    take       = load_valid && load_ready;
    pull       = (state_q == ST_IDLE) && shift_en && hold_full_q && !abort;
    busy       = hold_full_q || (state_q == ST_SHIFT);
    state_dbg  = state_q;
  end

  tdo_shift_reg #(
    .WIDTH      (WIDTH),
    .MSB_FIRST  (MSB_FIRST),
    .IDLE_LEVEL (IDLE_LEVEL)
  ) u_shift (
    .clk_tck   (clk_tck),
    .reset_n   (reset_n),
    .clear     (abort),
    .advance   (shift_en),
    .load      (pull),
    .load_word (aligned),
    .load_len  (hold_len_q),
    .tdo       (tdo),
    .done      (done),
    .last      (last_bit)
  );

endmodule

// File: tb/tb_jtag_tdo_serializer.sv
// Bench for jtag_tdo_serializer: an MSB-first 32-bit instance and an
// LSB-first 8-bit instance, driven by directed vectors into a scoreboard.
module tb_jtag_tdo_serializer;
  import jtag_pkg::*;

  logic clk_tck = 1'b1;
  logic reset_n = 1'b0;

  // MSB-first, WIDTH=32
  logic        m_load_valid, m_load_ready, m_shift_en, m_abort;
  logic [31:0] m_load_data;
  logic [5:0]  m_load_len;
  logic        m_tdo, m_busy, m_done;
  state_t      m_state;

  // LSB-first, WIDTH=8
  logic        l_load_valid, l_load_ready, l_shift_en, l_abort;
  logic [7:0]  l_load_data;
  logic [3:0]  l_load_len;
  logic        l_tdo, l_busy, l_done;
  state_t      l_state;

  // entry: {test[3:0], step[7:0], sel, tdo, done, busy, ready}
  logic [16:0] exp_q[$];
  logic [7:0]  step_idx = '0;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk_tck = ~clk_tck;

  jtag_tdo_serializer #(.WIDTH(32), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_msb (
    .clk_tck    (clk_tck),
    .reset_n    (reset_n),
    .load_valid (m_load_valid),
    .load_ready (m_load_ready),
    .load_data  (m_load_data),
    .load_len   (m_load_len),
    .shift_en   (m_shift_en),
    .abort      (m_abort),
    .tdo        (m_tdo),
    .busy       (m_busy),
    .done       (m_done),
    .state_dbg  (m_state)
  );

  jtag_tdo_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk_tck    (clk_tck),
    .reset_n    (reset_n),
    .load_valid (l_load_valid),
    .load_ready (l_load_ready),
    .load_data  (l_load_data),
    .load_len   (l_load_len),
    .shift_en   (l_shift_en),
    .abort      (l_abort),
    .tdo        (l_tdo),
    .busy       (l_busy),
    .done       (l_done),
    .state_dbg  (l_state)
  );

  function automatic logic [3:0] ex(input bit t, input bit dn, input bit b, input bit r);
    return {t, dn, b, r};
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  // Drive one falling edge on the selected instance and queue its expected outputs.
  task automatic step(input int test, input bit sel, input bit v, input logic [31:0] d,
                      input logic [5:0] l, input bit se, input bit ab, input logic [3:0] e);
    @(posedge clk_tck);
    m_load_valid = 1'b0; m_shift_en = 1'b0; m_abort = 1'b0;
    l_load_valid = 1'b0; l_shift_en = 1'b0; l_abort = 1'b0;
    if (!sel) begin
      m_load_valid = v; m_load_data = d; m_load_len = l; m_shift_en = se; m_abort = ab;
    end else begin
      l_load_valid = v; l_load_data = d[7:0]; l_load_len = l[3:0]; l_shift_en = se; l_abort = ab;
    end
    exp_q.push_back({4'(test), step_idx, sel, e});
    step_idx++;
    @(negedge clk_tck);
  endtask

  // Monitor: compares the sampled outputs after each falling edge.
  initial begin
    logic [16:0] ent;
    logic [3:0]  act;
    forever begin
      @(negedge clk_tck);
      #1;
      if (exp_q.size() > 0) begin
        ent = exp_q.pop_front();
        act = ent[4] ? {l_tdo, l_done, l_busy, l_load_ready}
                     : {m_tdo, m_done, m_busy, m_load_ready};
        n_checks++;
        if (act !== ent[3:0]) begin
          n_fail++;
          $display("FAIL test%0d step%0d {tdo,done,busy,ready} got %b want %b",
                   ent[16:13], ent[12:5], act, ent[3:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    m_load_valid = 0; m_load_data = '0; m_load_len = '0; m_shift_en = 0; m_abort = 0;
    l_load_valid = 0; l_load_data = '0; l_load_len = '0; l_shift_en = 0; l_abort = 0;

    // Reset values while reset is held
    #2;
    check1("rst_m_tdo",   m_tdo, 1'b0);
    check1("rst_m_done",  m_done, 1'b0);
    check1("rst_m_busy",  m_busy, 1'b0);
    check1("rst_m_ready", m_load_ready, 1'b1);
    check1("rst_m_idle",  m_state == ST_IDLE, 1'b1);
    check1("rst_l_tdo",   l_tdo, 1'b0);
    check1("rst_l_busy",  l_busy, 1'b0);
    check1("rst_l_idle",  l_state == ST_IDLE, 1'b1);
    #10 reset_n = 1'b1;

    // 1: idle with shift_en high
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 1));

    // 2: 0xA5000000, len 0 -> 32 bits MSB first
    w = 32'hA500_0000;
    step(2, 0, 1, w, 6'd0, 1, 0, ex(0, 0, 1, 0));
    for (int k = 1; k <= 32; k++) step(2, 0, 0, 0, 0, 1, 0, ex(w[32-k], k == 32, k != 32, 1));
    step(2, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 1));

    // 3: back-to-back 0x3/2 then 0x5/3 -> 1,1,1,0,1
    step(3, 0, 1, 32'h3, 6'd2, 1, 0, ex(0, 0, 1, 0));
    step(3, 0, 0, 0,     0,    1, 0, ex(1, 0, 1, 1));
    step(3, 0, 1, 32'h5, 6'd3, 1, 0, ex(1, 1, 1, 0));
    step(3, 0, 0, 0,     0,    1, 0, ex(1, 0, 1, 1));
    step(3, 0, 0, 0,     0,    1, 0, ex(0, 0, 1, 1));
    step(3, 0, 0, 0,     0,    1, 0, ex(1, 1, 0, 1));
    step(3, 0, 0, 0,     0,    1, 0, ex(0, 0, 0, 1));

    // 4: 0xF0/8 with a 4-edge pause after the fourth bit
    step(4, 0, 1, 32'hF0, 6'd8, 0, 0, ex(0, 0, 1, 0));
    for (int k = 1; k <= 4; k++) step(4, 0, 0, 0, 0, 1, 0, ex(1, 0, 1, 1));
    for (int k = 0; k < 4; k++)  step(4, 0, 0, 0, 0, 0, 0, ex(1, 0, 1, 1));
    for (int k = 5; k <= 7; k++) step(4, 0, 0, 0, 0, 1, 0, ex(0, 0, 1, 1));
    step(4, 0, 0, 0, 0, 1, 0, ex(0, 1, 0, 1));
    step(4, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 1));

    // 5: abort after five bits of 0xBEEF/16 with 0x1234/8 held
    step(5, 0, 1, 32'hBEEF, 6'd16, 0, 0, ex(0, 0, 1, 0));
    step(5, 0, 0, 0,        0,     1, 0, ex(1, 0, 1, 1));
    step(5, 0, 1, 32'h1234, 6'd8,  1, 0, ex(0, 0, 1, 0));
    step(5, 0, 0, 0,        0,     1, 0, ex(1, 0, 1, 0));
    step(5, 0, 0, 0,        0,     1, 0, ex(1, 0, 1, 0));
    step(5, 0, 0, 0,        0,     1, 0, ex(1, 0, 1, 0));
    step(5, 0, 1, 32'h55,   6'd4,  1, 1, ex(0, 0, 0, 0));
    step(5, 0, 0, 0,        0,     1, 0, ex(0, 0, 0, 1));
    step(5, 0, 0, 0,        0,     1, 0, ex(0, 0, 0, 1));

    // 6: LSB first: 0x1/1, 0x6/3, 0x81 with oversize length
    step(6, 1, 1, 32'h1, 6'd1, 0, 0, ex(0, 0, 1, 0));
    step(6, 1, 0, 0,     0,    1, 0, ex(1, 1, 0, 1));
    step(6, 1, 0, 0,     0,    1, 0, ex(0, 0, 0, 1));
    step(6, 1, 1, 32'h6, 6'd3, 0, 0, ex(0, 0, 1, 0));
    step(6, 1, 0, 0,     0,    1, 0, ex(0, 0, 1, 1));
    step(6, 1, 0, 0,     0,    1, 0, ex(1, 0, 1, 1));
    step(6, 1, 0, 0,     0,    1, 0, ex(1, 1, 0, 1));
    step(6, 1, 0, 0,     0,    1, 0, ex(0, 0, 0, 1));
    w = 32'h81;
    step(6, 1, 1, w, 6'd15, 0, 0, ex(0, 0, 1, 0));
    for (int k = 1; k <= 8; k++) step(6, 1, 0, 0, 0, 1, 0, ex(w[k-1], k == 8, k != 8, 1));
    step(6, 1, 0, 0, 0, 1, 0, ex(0, 0, 0, 1));

    // 7: reset in the middle of a word
    step(7, 0, 1, 32'hFFFF_FFFF, 6'd0, 0, 0, ex(0, 0, 1, 0));
    step(7, 0, 0, 0, 0, 1, 0, ex(1, 0, 1, 1));
    step(7, 0, 0, 0, 0, 1, 0, ex(1, 0, 1, 1));
    @(posedge clk_tck);
    #2 reset_n = 1'b0;
    #1;
    check1("midrst_tdo",   m_tdo, 1'b0);
    check1("midrst_done",  m_done, 1'b0);
    check1("midrst_busy",  m_busy, 1'b0);
    check1("midrst_ready", m_load_ready, 1'b1);
    check1("midrst_idle",  m_state == ST_IDLE, 1'b1);
    @(posedge clk_tck);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(7, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 1));

    @(negedge clk_tck);
    #3;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
